// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: sequences select changes for a glitch-free clock mux with a settle
// window after each change; defining CLK_SEL_CTRL_DWELL_EN adds a post-done dwell.
module clk_sel_ctrl #(
    parameter int NUM_INPUTS    = 4,
    parameter int SEL_W         = $clog2(NUM_INPUTS),
    parameter int SETTLE_CYCLES = 16,
    parameter int RESET_SEL     = 0,
    parameter int MIN_DWELL     = 32
) (
    input  logic             clk_i,
    input  logic             async_rstn_i,
    input  logic             req_valid_i,
    input  logic [SEL_W-1:0] req_sel_i,
    output logic             req_ready_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    // One counter serves both the settle and dwell windows, so size it for the longer.
    localparam int CNT_MAX = (SETTLE_CYCLES > MIN_DWELL) ? SETTLE_CYCLES : MIN_DWELL;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef CLK_SEL_CTRL_DWELL_EN
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'((MIN_DWELL > 0) ? MIN_DWELL - 1 : 0);
`endif
    localparam logic [SEL_W:0]   SEL_LIMIT   = (SEL_W+1)'(NUM_INPUTS);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SETTLE,
        S_DONE
`ifdef CLK_SEL_CTRL_DWELL_EN
        , S_DWELL
`endif
    } state_t;

    state_t           r_state, w_state_d;
    logic [SEL_W-1:0] r_sel, w_sel_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_bad, w_bad_d;
    logic             w_req_bad;

    assign w_req_bad   = {1'b0, req_sel_i} >= SEL_LIMIT;
    assign req_ready_o = (r_state == S_IDLE);
    assign busy_o      = !(r_state inside {S_INIT, S_IDLE});
    assign done_o      = (r_state == S_DONE) && !r_bad;
    assign err_o       = (r_state == S_DONE) && r_bad;
    assign sel_o       = r_sel;

    // State, select, counter and error-flag registers; reset discards any switch in flight.
    always_ff @(posedge clk_i or negedge async_rstn_i) begin
        if (!async_rstn_i) begin
            r_state <= S_INIT;
            r_sel   <= SEL_W'(RESET_SEL);
            r_cnt   <= '0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel_d;
            r_cnt   <= w_cnt_d;
            r_bad   <= w_bad_d;
        end
    end

    // Next-state logic: the select moves only on a legal, differing accept in IDLE.
    always_comb begin
        w_state_d = r_state;
        w_sel_d   = r_sel;
        w_cnt_d   = r_cnt;
        w_bad_d   = r_bad;
        case (r_state)
            S_INIT: w_state_d = S_IDLE;
            S_IDLE: begin
                if (req_valid_i) begin
                    w_bad_d = w_req_bad;
                    if (w_req_bad || req_sel_i == r_sel) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_sel_d   = req_sel_i;
                        w_cnt_d   = SETTLE_LOAD;
                        w_state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                w_state_d = (r_cnt == '0) ? S_DONE : S_SETTLE;
                w_cnt_d   = (r_cnt == '0) ? r_cnt : r_cnt - CNT_W'(1);
            end
            S_DONE: begin
`ifdef CLK_SEL_CTRL_DWELL_EN
                w_state_d = (MIN_DWELL > 0) ? S_DWELL : S_IDLE;
                w_cnt_d   = DWELL_LOAD;
`else
                w_state_d = S_IDLE;
`endif
            end
`ifdef CLK_SEL_CTRL_DWELL_EN
            S_DWELL: begin
                w_state_d = (r_cnt == '0) ? S_IDLE : S_DWELL;
                w_cnt_d   = (r_cnt == '0) ? r_cnt : r_cnt - CNT_W'(1);
            end
`endif
            default: w_state_d = S_INIT;
        endcase
    end
endmodule
